reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Architectural register file with per-register rename tags, sitting directly downstream of the ROB commit port and beside the decoder.
- Holds 32 committed 32-bit values. Each register carries a ROB-index tag naming the in-flight producer.
- The decoder reads operand value/busy/tag and renames rd on issue. The ROB writes committed results. A ROB rollback clears every tag.

Parameters:
- REG_NUM, 32, number of architectural registers (index width 5).
- ROB_BIT, 4, ROB index width. Index 0 is never allocated by the ROB and means "no producer".

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- rdy  input  1  global ready; low freezes all state
- rob_rb_ena  input  1  ROB rollback/flush pulse
- rob_wr_ena  input  1  commit write strobe
- rob_wr_rd  input  5  commit destination register
- rob_wr_val  input  32  commit value
- rob_wr_idx  input  ROB_BIT  ROB index of committing entry
- id_rn_ena  input  1  decoder issues an instruction with rd
- id_rn_rd  input  5  issued destination register
- id_rn_tag  input  ROB_BIT  ROB index allocated to issued instruction
- id_rs1  input  5  source register 1
- id_rs2  input  5  source register 2
- id_rs1_busy  output  1  rs1 has a pending producer
- id_rs1_tag  output  ROB_BIT  producer ROB index for rs1 (0 when not busy)
- id_rs1_val  output  32  committed value of rs1
- id_rs2_busy  output  1  as rs1
- id_rs2_tag  output  ROB_BIT  as rs1
- id_rs2_val  output  32  as rs1

Behaviour:
- Storage: val[0..31] is 32 bits and tag[0..31] is ROB_BIT bits. A register is busy iff its tag is nonzero.
- Reads are combinational, with zero latency. busy = (tag != 0); the tag output is the stored tag; the value output is the stored val.
- x0: reads always return val 0, busy 0, tag 0. Renames and commits targeting x0 are ignored.
- Reset (rst high at posedge): all val = 0 and all tag = 0. Every output therefore reads 0 from the next cycle. rst has priority over rdy and all other inputs.
- rdy low: no state changes. Reads remain valid.
- Commit (rob_wr_ena, rd != 0):
  - val[rd] <= rob_wr_val.
  - tag[rd] <= 0 only if tag[rd] == rob_wr_idx. A younger rename is preserved.
- Rename (id_rn_ena, rd != 0, rob_rb_ena low): tag[rd] <= id_rn_tag. id_rn_tag = 0 is illegal and must be flagged by the verification bench.
- Same-cycle commit and rename to the same rd: val is written and the tag becomes id_rn_tag. Rename wins the tag update.
- Same-cycle rename and read of the same register: the read returns the pre-rename state. An instruction never depends on its own rd.
- Rollback (rob_rb_ena high):
  - All 32 tags are cleared to 0 at that edge.
  - A commit presented in the same cycle still writes val. The ROB commits a JALR and raises rollback together.
  - Any rename in that cycle is dropped.
- Priority per edge: rst > !rdy (hold) > {commit val write, then tag: rollback clear > rename > commit clear}.
- No handshake: all inputs are single-cycle strobes sampled at posedge.

Optional Feature:
- Macro: REG_COMMIT_BYPASS_EN.
- Defined: when rob_wr_ena is high, rob_wr_rd == rsN != 0, and tag[rsN] == rob_wr_idx, the read of rsN returns val = rob_wr_val, busy 0, tag 0 in the same cycle. This removes the one-cycle window where the ROB entry is already retired but the tag is still set.
- Undefined: reads return stored state only. The decoder resolves the window through the ROB forwarding path.

Test Plan:
- Reset then read x5 and x31 -> val 0, busy 0, tag 0. Rename x0 with tag 3, then read x0 -> busy 0, val 0.
- Rename x5 tag 2, next cycle read x5 -> busy 1, tag 2. Commit x5 val 0xDEADBEEF idx 2, next cycle -> busy 0, val 0xDEADBEEF.
- Rename x7 tag 2, rename x7 tag 4, commit x7 idx 2 val 0x11 -> val 0x11, tag stays 4. Commit idx 4 val 0x22 -> busy 0, val 0x22.
- Same cycle: commit x9 idx 3 val 0x55 and rename x9 tag 6 -> val 0x55, tag 6.
- Rename x1/x2/x3 tags 1/2/3, then a cycle with rollback + commit x1 idx 1 val 0x1000 + rename x4 tag 5 -> all busy 0, x1 = 0x1000, x4 tag 0.
- rdy low during commit x6 val 0x77 -> x6 unchanged. With REG_COMMIT_BYPASS_EN, x6 tag 2 and commit idx 2 val 0x77 with rdy high -> same-cycle read gives val 0x77, busy 0.

Source files
------------

// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register ROB rename
// tags. Decoder reads operands combinationally and renames rd at issue; the
// ROB commits values and can roll back all tags at once.
// Optional build macro: REG_COMMIT_BYPASS_EN (same-cycle commit forwarding on reads).
module reg_rename_file #(
   parameter int unsigned REG_NUM = 32,
   parameter int unsigned ROB_BIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               rob_rb_ena,
   input  logic               rob_wr_ena,
   input  logic [4:0]         rob_wr_rd,
   input  logic [31:0]        rob_wr_val,
   input  logic [ROB_BIT-1:0] rob_wr_idx,
   input  logic               id_rn_ena,
   input  logic [4:0]         id_rn_rd,
   input  logic [ROB_BIT-1:0] id_rn_tag,
   input  logic [4:0]         id_rs1,
   input  logic [4:0]         id_rs2,
   output logic               id_rs1_busy,
   output logic [ROB_BIT-1:0] id_rs1_tag,
   output logic [31:0]        id_rs1_val,
   output logic               id_rs2_busy,
   output logic [ROB_BIT-1:0] id_rs2_tag,
   output logic [31:0]        id_rs2_val
);

   logic [31:0]        val_q [REG_NUM];
   logic [ROB_BIT-1:0] tag_q [REG_NUM];

   logic [ROB_BIT-1:0] rs1_tag;
   logic [31:0]        rs1_val;
   logic [ROB_BIT-1:0] rs2_tag;
   logic [31:0]        rs2_val;

   // State update: commit writes val; tag priority is rollback > rename > commit clear.
   // x0 is never touched after reset, so it always reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < REG_NUM; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else if (rdy) begin
         for (int unsigned i = 1; i < REG_NUM; i++) begin
            if (rob_wr_ena && rob_wr_rd == 5'(i))
               val_q[i] <= rob_wr_val;
            if (rob_rb_ena)
               tag_q[i] <= '0;
            else if (id_rn_ena && id_rn_rd == 5'(i))
               tag_q[i] <= id_rn_tag;
            else if (rob_wr_ena && rob_wr_rd == 5'(i) && tag_q[i] == rob_wr_idx)
               tag_q[i] <= '0;
         end
      end
   end

   // Operand read port 1: stored state, x0 forced to zero.
   always_comb begin
      rs1_tag = '0;
      rs1_val = '0;
      if (id_rs1 != '0) begin
         rs1_tag = tag_q[id_rs1];
         rs1_val = val_q[id_rs1];
`ifdef REG_COMMIT_BYPASS_EN
         if (rob_wr_ena && rob_wr_rd == id_rs1 && tag_q[id_rs1] == rob_wr_idx) begin
            rs1_tag = '0;
            rs1_val = rob_wr_val;
         end
`endif
      end
   end

   // Operand read port 2: stored state, x0 forced to zero.
   always_comb begin
      rs2_tag = '0;
      rs2_val = '0;
      if (id_rs2 != '0) begin
         rs2_tag = tag_q[id_rs2];
         rs2_val = val_q[id_rs2];
`ifdef REG_COMMIT_BYPASS_EN
         if (rob_wr_ena && rob_wr_rd == id_rs2 && tag_q[id_rs2] == rob_wr_idx) begin
            rs2_tag = '0;
            rs2_val = rob_wr_val;
         end
`endif
      end
   end

   assign id_rs1_tag  = rs1_tag;
   assign id_rs1_val  = rs1_val;
   assign id_rs1_busy = (rs1_tag != '0);
   assign id_rs2_tag  = rs2_tag;
   assign id_rs2_val  = rs2_val;
   assign id_rs2_busy = (rs2_tag != '0);

endmodule

// File: tb/tb_reg_rename_file.sv
// Testbench for reg_rename_file: directed literal checks followed by random
// stimulus compared every cycle against a behavioural register/tag model.
module tb_reg_rename_file;

   logic        clk = 1'b0;
   logic        rst, rdy, rob_rb_ena, rob_wr_ena, id_rn_ena;
   logic [4:0]  rob_wr_rd, id_rn_rd, id_rs1, id_rs2;
   logic [31:0] rob_wr_val;
   logic [3:0]  rob_wr_idx, id_rn_tag;
   logic        id_rs1_busy, id_rs2_busy;
   logic [3:0]  id_rs1_tag, id_rs2_tag;
   logic [31:0] id_rs1_val, id_rs2_val;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   logic [31:0] m_val [32];
   logic [3:0]  m_tag [32];

   reg_rename_file #(.REG_NUM(32), .ROB_BIT(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rob_rb_ena(rob_rb_ena),
      .rob_wr_ena(rob_wr_ena), .rob_wr_rd(rob_wr_rd), .rob_wr_val(rob_wr_val),
      .rob_wr_idx(rob_wr_idx), .id_rn_ena(id_rn_ena), .id_rn_rd(id_rn_rd),
      .id_rn_tag(id_rn_tag), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_busy(id_rs1_busy), .id_rs1_tag(id_rs1_tag), .id_rs1_val(id_rs1_val),
      .id_rs2_busy(id_rs2_busy), .id_rs2_tag(id_rs2_tag), .id_rs2_val(id_rs2_val)
   );

   always #5 clk = ~clk;

   function automatic logic [36:0] pk1();
      return {id_rs1_busy, id_rs1_tag, id_rs1_val};
   endfunction

   function automatic logic [36:0] pk2();
      return {id_rs2_busy, id_rs2_tag, id_rs2_val};
   endfunction

   // Expected read of register rs given the model state and current commit inputs.
   function automatic logic [36:0] exp_read(input logic [4:0] rs);
      logic [3:0]  t;
      logic [31:0] v;
      if (rs == 5'd0) return '0;
      t = m_tag[rs];
      v = m_val[rs];
`ifdef REG_COMMIT_BYPASS_EN
      if (rob_wr_ena && rob_wr_rd == rs && m_tag[rs] == rob_wr_idx) begin
         t = 4'd0;
         v = rob_wr_val;
      end
`endif
      return {(t != 4'd0), t, v};
   endfunction

   task automatic chk(input string name, input logic [36:0] got, input logic [36:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got busy=%0b tag=%0d val=%h, expected busy=%0b tag=%0d val=%h",
                  name, got[36], got[35:32], got[31:0], exp[36], exp[35:32], exp[31:0]);
      end
   endtask

   task automatic idle();
      rst = 0; rdy = 1; rob_rb_ena = 0; rob_wr_ena = 0; rob_wr_rd = 0;
      rob_wr_val = 0; rob_wr_idx = 0; id_rn_ena = 0; id_rn_rd = 0; id_rn_tag = 0;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [3:0] idx, input logic [31:0] v);
      rob_wr_ena = 1; rob_wr_rd = rd; rob_wr_idx = idx; rob_wr_val = v;
   endtask

   task automatic rename(input logic [4:0] rd, input logic [3:0] t);
      id_rn_ena = 1; id_rn_rd = rd; id_rn_tag = t;
   endtask

   // Reference model: apply one clock edge's effects in rule order, later rules win.
   always @(posedge clk) begin
      logic [3:0] old_tag;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_tag[i] = '0;
         end
      end else if (rdy) begin
         if (id_rn_ena && !rob_rb_ena) begin
            n_cmp++;
            if (id_rn_tag == 4'd0) begin
               n_err++;
               $display("FAIL rename_tag_nonzero: got tag=%0d for rd=%0d, required nonzero",
                        id_rn_tag, id_rn_rd);
            end
         end
         old_tag = m_tag[rob_wr_rd];
         if (rob_wr_ena && rob_wr_rd != 5'd0) m_val[rob_wr_rd] = rob_wr_val;
         if (rob_rb_ena) begin
            for (int i = 0; i < 32; i++) m_tag[i] = '0;
         end else begin
            if (rob_wr_ena && rob_wr_rd != 5'd0 && old_tag == rob_wr_idx)
               m_tag[rob_wr_rd] = '0;
            if (id_rn_ena && id_rn_rd != 5'd0)
               m_tag[id_rn_rd] = id_rn_tag;
         end
      end
   end

   // Compare process: checks both read ports against the model every cycle.
   always @(negedge clk) begin
      #2;
      if (chk_en) begin
         chk("model_rs1", pk1(), exp_read(id_rs1));
         chk("model_rs2", pk2(), exp_read(id_rs2));
      end
   end

   initial begin
      idle();
      rst = 1; id_rs1 = 0; id_rs2 = 0;
      @(negedge clk);
      @(negedge clk);

      // Reset values and x0 rename ignored
      idle(); id_rs1 = 5; id_rs2 = 31; chk_en = 1;
      #3;
      chk("reset_x5", pk1(), 37'd0);
      chk("reset_x31", pk2(), 37'd0);
      rename(0, 3);
      @(negedge clk);
      idle(); id_rs1 = 0;
      #3;
      chk("x0_after_rename", pk1(), 37'd0);
      rename(5, 2);
      @(negedge clk);

      // Rename then commit x5
      idle(); id_rs1 = 5;
      #3;
      chk("x5_renamed", pk1(), {1'b1, 4'd2, 32'd0});
      commit(5, 2, 32'hDEADBEEF);
      @(negedge clk);
      idle(); id_rs1 = 5;
      #3;
      chk("x5_committed", pk1(), {1'b0, 4'd0, 32'hDEADBEEF});

      // Younger rename preserved across older commit
      rename(7, 2);
      @(negedge clk);
      idle(); rename(7, 4);
      @(negedge clk);
      idle(); commit(7, 2, 32'h11);
      @(negedge clk);
      idle(); id_rs1 = 7;
      #3;
      chk("x7_older_commit", pk1(), {1'b1, 4'd4, 32'h11});
      commit(7, 4, 32'h22);
      @(negedge clk);
      idle(); id_rs1 = 7;
      #3;
      chk("x7_final_commit", pk1(), {1'b0, 4'd0, 32'h22});

      // Same-cycle commit and rename to x9
      commit(9, 3, 32'h55); rename(9, 6);
      @(negedge clk);
      idle(); id_rs1 = 9;
      #3;
      chk("x9_commit_rename", pk1(), {1'b1, 4'd6, 32'h55});
      rename(1, 1);
      @(negedge clk);
      idle(); rename(2, 2);
      @(negedge clk);
      idle(); rename(3, 3);
      @(negedge clk);

      // Rollback with commit and dropped rename
      idle(); rob_rb_ena = 1; commit(1, 1, 32'h1000); rename(4, 5);
      @(negedge clk);
      idle(); id_rs1 = 1; id_rs2 = 4;
      #3;
      chk("rb_x1", pk1(), {1'b0, 4'd0, 32'h1000});
      chk("rb_x4", pk2(), {1'b0, 4'd0, 32'h0});
      id_rs1 = 2; id_rs2 = 3;
      #1;
      chk("rb_x2", pk1(), {1'b0, 4'd0, 32'h0});
      chk("rb_x3", pk2(), {1'b0, 4'd0, 32'h0});
      @(negedge clk);

      // rdy low freezes a commit
      idle(); rdy = 0; commit(6, 1, 32'h77); id_rs1 = 6;
      @(negedge clk);
      idle(); id_rs1 = 6;
      #3;
      chk("x6_frozen", pk1(), {1'b0, 4'd0, 32'h0});
      rename(6, 2);
      @(negedge clk);
      idle(); id_rs1 = 6;
      #3;
      chk("x6_renamed", pk1(), {1'b1, 4'd2, 32'h0});
      commit(6, 2, 32'h77);
      #1;
`ifdef REG_COMMIT_BYPASS_EN
      chk("x6_same_cycle", pk1(), {1'b0, 4'd0, 32'h77});
`else
      chk("x6_same_cycle", pk1(), {1'b1, 4'd2, 32'h0});
`endif
      @(negedge clk);
      idle(); id_rs1 = 6;
      #3;
      chk("x6_committed", pk1(), {1'b0, 4'd0, 32'h77});
      @(negedge clk);

      // Random phase
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         rdy        = ($urandom_range(0, 9) != 0);
         rob_rb_ena = ($urandom_range(0, 15) == 0);
         rob_wr_ena = 1'($urandom_range(0, 1));
         rob_wr_rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         rob_wr_val = $urandom;
         if ($urandom_range(0, 2) != 0 && m_tag[rob_wr_rd] != 4'd0)
            rob_wr_idx = m_tag[rob_wr_rd];
         else
            rob_wr_idx = 4'($urandom_range(1, 15));
         id_rn_ena  = 1'($urandom_range(0, 1));
         id_rn_rd   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         id_rn_tag  = 4'($urandom_range(1, 15));
         id_rs1     = ($urandom_range(0, 2) == 0) ? rob_wr_rd : 5'($urandom_range(0, 7));
         id_rs2     = ($urandom_range(0, 2) == 0) ? id_rn_rd : 5'($urandom_range(0, 31));
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
